mxv_mac_seq: RTL and testbench
==============================

Name: mxv_mac_seq

Overview:
- Sequencer that computes a signed matrix-vector product O = G·E (G is MxK, E is K) on one shared mac_nnbit_kcc instance.
- Fetches G and E from two external synchronous-read memories and feeds one product per cycle.
- Pulses the MAC reset between rows and hands each row result out on a valid/ready stream.
- Sits between the operand memories and the MAC in the vdp benchmark datapath.

Parameters:
- N, 8: signed operand bit-width.
- K, 3: vector dimension, i.e. products per row; K>=1.
- M, 3: number of matrix rows; M>=1.
- W, 2*N+K-1: result width; must match the MAC output width.
- GAW, max(1,$clog2(M*K)): G address width.
- EAW, max(1,$clog2(K)): E address width.
- RW, max(1,$clog2(M)): row-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new MxK pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the final CLR cycle, inclusive.
- done  out  1  one-cycle pulse in the first IDLE cycle after the last row.
- g_rd_en  out  1  G memory read strobe.
- g_addr  out  GAW  G read address, row-major: m*K+k.
- g_rdata  in  N  signed G data, valid 1 cycle after g_rd_en.
- e_rd_en  out  1  E memory read strobe.
- e_addr  out  EAW  E read address: k.
- e_rdata  in  N  signed E data, valid 1 cycle after e_rd_en.
- mac_rst  out  1  reset to the MAC (MAC clears asynchronously).
- mac_g  out  N  MAC g_input, registered.
- mac_e  out  N  MAC e_input, registered.
- mac_o  in  W  MAC accumulator output.
- o_valid  out  1  row result valid.
- o_ready  in  1  downstream accepts the result.
- o_data  out  W  signed row sum.
- o_row  out  RW  row index m of o_data.

Behaviour:
- Reset values: state=IDLE, m=0, k=0, all read enables 0, all addresses 0, mac_g=0, mac_e=0, o_valid=0, o_data=0, o_row=0, busy=0, done=0, mac_rst=1. Reset mid-pass aborts immediately; a pending result is discarded.
- MAC contract: on each edge, acc<=acc+g*e unless reset. The controller therefore drives mac_g=mac_e=0 on every cycle that does not carry a valid product.
- State IDLE: mac_rst=1. When start=1, go to ISSUE with m=0, k=0.
- State ISSUE (K cycles): g_rd_en=e_rd_en=1, g_addr=m*K+k, e_addr=k, then k++. After k=K-1, go to DRAIN.
- Operand pipeline: a 1-bit read-valid delay tracks issued reads. On the edge where it is 1, mac_g<=g_rdata and mac_e<=e_rdata; otherwise both load 0. Operand k is therefore at the MAC 2 cycles after it was issued.
- State DRAIN (2 cycles): no reads are issued. After DRAIN, mac_o holds the full row sum.
- State CAPT: if o_valid=0 or o_ready=1, then o_data<=mac_o, o_row<=m, o_valid<=1, and go to CLR. Otherwise stall in CAPT. mac_o stays stable during a stall because operands are 0.
- State CLR (1 cycle): mac_rst=1. If m==M-1, go to IDLE and pulse done. Otherwise m++, k=0, go to ISSUE.
- Row period without stall is K+4 cycles. The first result has o_valid=1 at cycle K+4 after the start edge.
- Output handshake: one-entry output register. A transfer occurs on an edge with o_valid&o_ready; o_valid then clears unless a capture happens on the same edge. Simultaneous transfer and capture is allowed: the new data wins and o_valid stays 1.
- start while busy is ignored. start on the same cycle as the done pulse is accepted.
- Arithmetic: the sum is a full-precision signed W-bit value and the controller never truncates it. W is sized so that K·(-2^(N-1))² fits.
- Boundaries:
  - K=1: ISSUE lasts 1 cycle.
  - M=1: done follows the first CLR.
  - The last result may still have o_valid=1 while done pulses and IDLE is entered; it remains held until accepted.

Test Plan:
- N=8,K=3,M=3; G={29,74,-39},{67,-71,56},{75,-45,34}; E={-38,-91,47}; o_ready=1 -> o_data=-9669, 6547, 2843 with o_row 0,1,2; results 7 cycles apart; done one cycle after the third CLR.
- Same data with o_ready held 0 for 20 cycles after the first result -> controller stalls in CAPT; mac_g=mac_e=0 during the stall; after release the sequence -9669, 6547, 2843 arrives with no loss or duplication.
- All G=-128 and all E=-128, K=3 -> every row gives 49152 (18-bit, no overflow); all G=127 and all E=-128 -> every row gives -48768.
- rst asserted mid-ISSUE of row 1 -> all outputs return to their reset values immediately, including mac_rst=1; a new start reruns from row 0 with correct sums.
- start pulsed while busy -> ignored, no extra rows. start coincident with done -> a second pass runs back to back.
- K=1, M=1, G=-5, E=7 -> a single result of -35 on o_row=0, with done pulsed.

Source files
------------

// File: rtl/mxv_mac_seq.sv
// Signed matrix-vector product O = G*E, sequenced one product per cycle onto a single shared MAC.
// Latency: first row result K+4 cycles after start is sampled (start edge counted), one row per K+4 cycles.
// Backpressure: one-entry output register; the sequencer holds in CAPT while it is full and not accepted.
module mxv_mac_seq #(
    parameter int N   = 8,
    parameter int K   = 3,
    parameter int M   = 3,
    parameter int W   = 2*N+K-1,
    parameter int GAW = (M*K > 1) ? $clog2(M*K) : 1,
    parameter int EAW = (K > 1) ? $clog2(K) : 1,
    parameter int RW  = (M > 1) ? $clog2(M) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           g_rd_en,
    output logic [GAW-1:0] g_addr,
    input  logic [N-1:0]   g_rdata,
    output logic           e_rd_en,
    output logic [EAW-1:0] e_addr,
    input  logic [N-1:0]   e_rdata,
    output logic           mac_rst,
    output logic [N-1:0]   mac_g,
    output logic [N-1:0]   mac_e,
    input  logic [W-1:0]   mac_o,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [W-1:0]   o_data,
    output logic [RW-1:0]  o_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN0,
        S_DRAIN1,
        S_CAPT,
        S_CLR
    } state_t;

    localparam logic [EAW-1:0] K_LAST = EAW'(K-1);
    localparam logic [RW-1:0]  M_LAST = RW'(M-1);

    state_t         state_q, state_d;
    logic [RW-1:0]  m_q, m_d;
    logic [EAW-1:0] k_q, k_d;
    // G is read row-major, so its address is simply a running counter across the pass.
    logic [GAW-1:0] ga_q, ga_d;
    logic           rv_q;
    logic [N-1:0]   mac_g_q, mac_e_q;
    logic           o_valid_q, o_valid_d;
    logic [W-1:0]   o_data_q, o_data_d;
    logic [RW-1:0]  o_row_q, o_row_d;
    logic           done_q, done_d;
    logic           capture;

    // Sequencer next state plus the strobes that depend only on the current state.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        ga_d    = ga_q;
        done_d  = 1'b0;
        capture = 1'b0;
        g_rd_en = 1'b0;
        e_rd_en = 1'b0;
        mac_rst = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mac_rst = 1'b1;
                if (start) begin
                    state_d = S_ISSUE;
                    m_d     = '0;
                    k_d     = '0;
                    ga_d    = '0;
                end
            end
            S_ISSUE: begin
                g_rd_en = 1'b1;
                e_rd_en = 1'b1;
                ga_d    = ga_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN0: state_d = S_DRAIN1;
            S_DRAIN1: state_d = S_CAPT;
            S_CAPT: begin
                // Operands are zero here, so mac_o holds the row sum for as long as we wait.
                if (!o_valid_q || o_ready) begin
                    capture = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                mac_rst = 1'b1;
                if (m_q == M_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    m_d     = m_q + 1'b1;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One-entry output register: a same-edge capture overrides the transfer that empties it.
    always_comb begin
        o_valid_d = capture | (o_valid_q & ~o_ready);
        o_data_d  = capture ? mac_o : o_data_q;
        o_row_d   = capture ? m_q : o_row_q;
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            k_q     <= '0;
            ga_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            ga_q    <= ga_d;
            done_q  <= done_d;
        end
    end

    // Operand pipeline: zero is fed on every cycle that does not carry a returned read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q    <= 1'b0;
            mac_g_q <= '0;
            mac_e_q <= '0;
        end else begin
            rv_q    <= g_rd_en;
            mac_g_q <= rv_q ? g_rdata : '0;
            mac_e_q <= rv_q ? e_rdata : '0;
        end
    end

    // Output result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_row_q   <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_row_q   <= o_row_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign g_addr  = ga_q;
    assign e_addr  = k_q;
    assign mac_g   = mac_g_q;
    assign mac_e   = mac_e_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_row   = o_row_q;

endmodule

// File: tb/tb_mxv_mac_seq.sv
// Bench for mxv_mac_seq: behavioural memories and MAC around the DUT, row sums from plain arithmetic.
// Main instance N=8,K=3,M=3; a second instance covers K=1,M=1.
// Downstream ready is driven per cycle to exercise stalls, reset abort and back-to-back passes.
module tb_mxv_mac_seq;
    localparam int N   = 8;
    localparam int K   = 3;
    localparam int M   = 3;
    localparam int W   = 2*N+K-1;
    localparam int GAW = 4;
    localparam int EAW = 2;
    localparam int RW  = 2;
    localparam int W1  = 2*N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start, busy, done, g_rd_en, e_rd_en, mac_rst, o_valid, o_ready;
    logic [GAW-1:0] g_addr;
    logic [EAW-1:0] e_addr;
    logic signed [N-1:0] g_rdata, e_rdata, mac_g, mac_e;
    logic signed [W-1:0] acc, o_data;
    logic [RW-1:0] o_row;

    logic start1, busy1, done1, g1_rd_en, e1_rd_en, mac1_rst, o1_valid, o1_ready;
    logic [0:0] g1_addr, e1_addr, o1_row;
    logic signed [N-1:0] g1_rdata, e1_rdata, mac1_g, mac1_e, gval1, eval1;
    logic signed [W1-1:0] acc1, o1_data;

    mxv_mac_seq #(.N(N), .K(K), .M(M)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .g_rd_en(g_rd_en), .g_addr(g_addr), .g_rdata(g_rdata),
        .e_rd_en(e_rd_en), .e_addr(e_addr), .e_rdata(e_rdata),
        .mac_rst(mac_rst), .mac_g(mac_g), .mac_e(mac_e), .mac_o(acc),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_row(o_row)
    );

    mxv_mac_seq #(.N(N), .K(1), .M(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .g_rd_en(g1_rd_en), .g_addr(g1_addr), .g_rdata(g1_rdata),
        .e_rd_en(e1_rd_en), .e_addr(e1_addr), .e_rdata(e1_rdata),
        .mac_rst(mac1_rst), .mac_g(mac1_g), .mac_e(mac1_e), .mac_o(acc1),
        .o_valid(o1_valid), .o_ready(o1_ready), .o_data(o1_data), .o_row(o1_row)
    );

    // Operand memories with one-cycle synchronous read.
    logic signed [N-1:0] gmem [M*K];
    logic signed [N-1:0] emem [K];
    always @(posedge clk) begin
        if (g_rd_en) g_rdata <= gmem[int'(g_addr)];
        if (e_rd_en) e_rdata <= emem[int'(e_addr)];
        if (g1_rd_en) g1_rdata <= gval1;
        if (e1_rd_en) e1_rdata <= eval1;
    end

    // MACs: asynchronous clear, otherwise accumulate one product per edge.
    always @(posedge clk or posedge mac_rst)
        if (mac_rst) acc <= '0; else acc <= acc + mac_g * mac_e;
    always @(posedge clk or posedge mac1_rst)
        if (mac1_rst) acc1 <= '0; else acc1 <= acc1 + mac1_g * mac1_e;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int got_data[$], got_row[$], got_cyc[$], done_at[$];
    int stall_bad;
    logic busy_first;

    task automatic load_table();
        int gt[M*K] = '{29, 74, -39, 67, -71, 56, 75, -45, 34};
        int et[K]   = '{-38, -91, 47};
        for (int i = 0; i < M*K; i++) gmem[i] = N'(gt[i]);
        for (int i = 0; i < K; i++) emem[i] = N'(et[i]);
    endtask

    task automatic fill_const(input int gv, input int ev);
        for (int i = 0; i < M*K; i++) gmem[i] = N'(gv);
        for (int i = 0; i < K; i++) emem[i] = N'(ev);
    endtask

    // Reference: each row is the plain dot product of a G row with E.
    task automatic build_expect();
        exp_q.delete();
        for (int m = 0; m < M; m++) begin
            int s = 0;
            for (int k = 0; k < K; k++) s += int'(gmem[m*K+k]) * int'(emem[k]);
            exp_q.push_back(s);
        end
    endtask

    task automatic kick(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
    endtask

    // Runs a bounded number of cycles, driving ready/start and recording transfers and done pulses.
    task automatic collect(input int ncyc, input int stall_len, input int restarts, input int busy_kick);
        int stalled = 0;
        bit seen = 1'b0;
        logic signed [W-1:0] held = '0;
        got_data.delete(); got_row.delete(); got_cyc.delete(); done_at.delete();
        stall_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0) busy_first = busy;
            start = 1'b0;
            if (done) begin
                done_at.push_back(cyc);
                if (restarts > 0) begin start = 1'b1; restarts--; end
            end
            if (c == busy_kick) start = 1'b1;
            if (o_valid) seen = 1'b1;
            if (seen && stalled < stall_len) begin
                o_ready = 1'b0;
                stalled++;
                if (stalled == 1) held = o_data;
                if (stalled > stall_len - 10 && (mac_g !== 0 || mac_e !== 0 || o_data !== held || o_valid !== 1'b1))
                    stall_bad++;
            end else begin
                o_ready = 1'b1;
            end
            if (o_valid && o_ready) begin
                got_data.push_back(int'(o_data));
                got_row.push_back(int'(o_row));
                got_cyc.push_back(cyc);
            end
        end
        start = 1'b0;
        o_ready = 1'b1;
    endtask

    task automatic test_reset();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++; if (g_rd_en !== 1'b0 || e_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %b%b exp 00", g_rd_en, e_rd_en); end
        vectors++; if (g_addr !== 0 || e_addr !== 0) begin miscompares++; $display("FAIL reset_addr got %0d/%0d exp 0/0", g_addr, e_addr); end
        vectors++; if (mac_rst !== 1'b1) begin miscompares++; $display("FAIL reset_mac_rst got %b exp 1", mac_rst); end
        vectors++; if (mac_g !== 0 || mac_e !== 0) begin miscompares++; $display("FAIL reset_mac_ops got %0d/%0d exp 0/0", mac_g, mac_e); end
        vectors++; if (o_valid !== 1'b0 || o_data !== 0 || o_row !== 0) begin miscompares++; $display("FAIL reset_out got v%b d%0d r%0d exp v0 d0 r0", o_valid, o_data, o_row); end
    endtask

    task automatic test_basic();
        int s, lat, dl;
        load_table();
        build_expect();
        kick(s);
        collect(40, 0, 0, -1);
        vectors++; if (got_data.size() != M) begin miscompares++; $display("FAIL basic_count got %0d exp %0d", got_data.size(), M); end
        for (int i = 0; i < got_data.size() && i < M; i++) begin
            vectors++; if (got_data[i] != exp_q[i]) begin miscompares++; $display("FAIL basic_data[%0d] got %0d exp %0d", i, got_data[i], exp_q[i]); end
            vectors++; if (got_row[i] != i) begin miscompares++; $display("FAIL basic_row[%0d] got %0d exp %0d", i, got_row[i], i); end
        end
        lat = (got_cyc.size() > 0) ? got_cyc[0] - s : -1;
        vectors++; if (lat != K+4) begin miscompares++; $display("FAIL basic_latency got %0d exp %0d", lat, K+4); end
        for (int i = 1; i < got_cyc.size(); i++) begin
            vectors++; if (got_cyc[i] - got_cyc[i-1] != K+4) begin miscompares++; $display("FAIL basic_period[%0d] got %0d exp %0d", i, got_cyc[i] - got_cyc[i-1], K+4); end
        end
        vectors++; if (done_at.size() != 1) begin miscompares++; $display("FAIL basic_done_count got %0d exp 1", done_at.size()); end
        dl = (done_at.size() > 0) ? done_at[0] - s : -1;
        vectors++; if (dl != M*(K+4)+1) begin miscompares++; $display("FAIL basic_done_time got %0d exp %0d", dl, M*(K+4)+1); end
        vectors++; if (busy_first !== 1'b1) begin miscompares++; $display("FAIL basic_busy_start got %b exp 1", busy_first); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_stall();
        int s;
        load_table();
        build_expect();
        kick(s);
        collect(70, 20, 0, -1);
        vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL stall_hold got %0d bad cycles exp 0", stall_bad); end
        vectors++; if (got_data.size() != M) begin miscompares++; $display("FAIL stall_count got %0d exp %0d", got_data.size(), M); end
        for (int i = 0; i < got_data.size() && i < M; i++) begin
            vectors++; if (got_data[i] != exp_q[i] || got_row[i] != i) begin miscompares++; $display("FAIL stall_res[%0d] got %0d/r%0d exp %0d/r%0d", i, got_data[i], got_row[i], exp_q[i], i); end
        end
    endtask

    task automatic test_values(input int mode);
        int s;
        if (mode == 0) fill_const(-128, -128);
        else if (mode == 1) fill_const(127, -128);
        else begin
            for (int i = 0; i < M*K; i++) gmem[i] = N'($urandom);
            for (int i = 0; i < K; i++) emem[i] = N'($urandom);
        end
        build_expect();
        kick(s);
        collect(40, 0, 0, -1);
        vectors++; if (got_data.size() != M) begin miscompares++; $display("FAIL values%0d_count got %0d exp %0d", mode, got_data.size(), M); end
        for (int i = 0; i < got_data.size() && i < M; i++) begin
            vectors++; if (got_data[i] != exp_q[i] || got_row[i] != i) begin miscompares++; $display("FAIL values%0d_res[%0d] got %0d/r%0d exp %0d/r%0d", mode, i, got_data[i], got_row[i], exp_q[i], i); end
        end
    endtask

    task automatic test_reset_mid();
        int s;
        load_table();
        build_expect();
        kick(s);
        for (int c = 0; c < 40 && cyc < s + 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            o_ready = 1'b1;
        end
        vectors++; if (g_rd_en !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre got rd%b busy%b exp 1/1", g_rd_en, busy); end
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        kick(s);
        collect(40, 0, 0, -1);
        vectors++; if (got_data.size() != M) begin miscompares++; $display("FAIL abort_count got %0d exp %0d", got_data.size(), M); end
        for (int i = 0; i < got_data.size() && i < M; i++) begin
            vectors++; if (got_data[i] != exp_q[i] || got_row[i] != i) begin miscompares++; $display("FAIL abort_res[%0d] got %0d/r%0d exp %0d/r%0d", i, got_data[i], got_row[i], exp_q[i], i); end
        end
    endtask

    task automatic test_busy_start();
        int s;
        load_table();
        build_expect();
        kick(s);
        collect(50, 0, 0, 4);
        vectors++; if (got_data.size() != M) begin miscompares++; $display("FAIL busystart_count got %0d exp %0d", got_data.size(), M); end
        vectors++; if (done_at.size() != 1) begin miscompares++; $display("FAIL busystart_done got %0d exp 1", done_at.size()); end
    endtask

    task automatic test_back_to_back();
        int s, gap;
        load_table();
        build_expect();
        kick(s);
        collect(70, 0, 1, -1);
        vectors++; if (got_data.size() != 2*M) begin miscompares++; $display("FAIL b2b_count got %0d exp %0d", got_data.size(), 2*M); end
        for (int i = 0; i < got_data.size() && i < 2*M; i++) begin
            vectors++; if (got_data[i] != exp_q[i % M] || got_row[i] != i % M) begin miscompares++; $display("FAIL b2b_res[%0d] got %0d/r%0d exp %0d/r%0d", i, got_data[i], got_row[i], exp_q[i % M], i % M); end
        end
        vectors++; if (done_at.size() != 2) begin miscompares++; $display("FAIL b2b_done_count got %0d exp 2", done_at.size()); end
        gap = (done_at.size() > 1) ? done_at[1] - done_at[0] : -1;
        vectors++; if (gap != M*(K+4)+1) begin miscompares++; $display("FAIL b2b_done_gap got %0d exp %0d", gap, M*(K+4)+1); end
    endtask

    task automatic test_k1m1();
        int s, nres, res, row, rcyc, dcyc, ndone, expv;
        gval1 = -8'sd5;
        eval1 = 8'sd7;
        expv = int'(gval1) * int'(eval1);
        nres = 0; ndone = 0; res = 0; row = -1; rcyc = -1; dcyc = -1;
        @(negedge clk);
        start1 = 1'b1;
        s = cyc;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            o1_ready = 1'b1;
            if (done1) begin ndone++; dcyc = cyc - s; end
            if (o1_valid && o1_ready) begin nres++; res = int'(o1_data); row = int'(o1_row); rcyc = cyc - s; end
        end
        vectors++; if (nres != 1) begin miscompares++; $display("FAIL k1_count got %0d exp 1", nres); end
        vectors++; if (res != expv || row != 0) begin miscompares++; $display("FAIL k1_res got %0d/r%0d exp %0d/r0", res, row, expv); end
        vectors++; if (rcyc != 5) begin miscompares++; $display("FAIL k1_latency got %0d exp 5", rcyc); end
        vectors++; if (ndone != 1 || dcyc != 6) begin miscompares++; $display("FAIL k1_done got %0d at %0d exp 1 at 6", ndone, dcyc); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        o_ready = 1'b1;
        start1 = 1'b0;
        o1_ready = 1'b1;
        gval1 = '0;
        eval1 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_stall();
        test_values(0);
        test_values(1);
        for (int r = 0; r < 4; r++) test_values(2);
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        test_k1m1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
